// File: rtl/fdd_track_sched.sv
// Whole-track scheduler between the drive-0 SD block interface and the floppy
// track buffer: writes back a dirty track, then loads the new one sector by sector.
`timescale 1ns/1ps

module fdd_track_sched #(
   parameter int SECS  = 13,
   parameter int TRK_W = 6
) (
   input  logic             clk_sys,
   input  logic             reset_n,
   input  logic [TRK_W-1:0] track,
   input  logic             dirty_set,
   input  logic             img_mounted,
   input  logic             img_present,
   input  logic             img_readonly,
   input  logic             sd_ack,
   output logic [31:0]      sd_lba,
   output logic             sd_rd,
   output logic             sd_wr,
   output logic [3:0]       track_sec,
   output logic             cpu_wait,
   output logic             loaded,
   output logic             dirty
);

   // state | meaning
   // IDLE  | buffer owned by the disk controller; watches mounts and track moves
   // WB    | writing the old track back to the image, one sector per ack
   // RD    | loading the new track from the image, one sector per ack
   typedef enum logic [1:0] {IDLE, WB, RD} state_t;

   state_t            state_q, state_d;
   logic [TRK_W-1:0]  cur_track_q, cur_track_d;
   logic [TRK_W-1:0]  next_track_q, next_track_d;
   logic              mount_pend_q, mount_pend_d;
   logic              dirty_q, dirty_d;
   logic              loaded_q, loaded_d;
   logic [31:0]       lba_q, lba_d;
   logic              rd_q, rd_d;
   logic              wr_q, wr_d;
   logic [3:0]        sec_q, sec_d;
   logic              wait_q, wait_d;
   logic              ack_q, ack_d;
   logic              dirty_eff;
   logic              ack_rise;
   logic              ack_fall;

   function automatic logic [31:0] base(input logic [TRK_W-1:0] t);
      return 32'(SECS) * 32'(t);
   endfunction

   assign ack_rise = sd_ack & ~ack_q;
   assign ack_fall = ~sd_ack & ack_q;

   always_comb begin
      state_d      = state_q;
      cur_track_d  = cur_track_q;
      next_track_d = next_track_q;
      mount_pend_d = mount_pend_q | img_mounted;
      dirty_d      = dirty_q;
      loaded_d     = loaded_q;
      lba_d        = lba_q;
      rd_d         = rd_q;
      wr_d         = wr_q;
      sec_d        = sec_q;
      wait_d       = wait_q;
      ack_d        = sd_ack;
      dirty_eff    = dirty_q;

      case (state_q)
         IDLE: begin
            wait_d    = 1'b0;
            rd_d      = 1'b0;
            wr_d      = 1'b0;
            // a write landing on the same cycle as a track move still counts
            dirty_eff = dirty_q | (dirty_set & loaded_q & ~img_readonly);
            dirty_d   = dirty_eff;
            if (mount_pend_q) begin
               mount_pend_d = img_mounted;
               dirty_d      = 1'b0;
               loaded_d     = 1'b0;
               cur_track_d  = track;
               next_track_d = track;
               if (img_present) begin
                  state_d = RD;
                  lba_d   = base(track);
                  sec_d   = 4'd0;
                  rd_d    = 1'b1;
                  wait_d  = 1'b1;
               end
            end else if (track != cur_track_q) begin
               next_track_d = track;
               cur_track_d  = track;
               if (loaded_q & dirty_eff & ~img_readonly) begin
                  state_d = WB;
                  lba_d   = base(cur_track_q);
                  sec_d   = 4'd0;
                  wr_d    = 1'b1;
                  wait_d  = 1'b1;
               end else if (loaded_q | img_present) begin
                  state_d = RD;
                  lba_d   = base(track);
                  sec_d   = 4'd0;
                  rd_d    = 1'b1;
                  wait_d  = 1'b1;
               end
            end
         end

         WB, RD: begin
            wait_d = 1'b1;
            if (ack_rise) begin
               rd_d = 1'b0;
               wr_d = 1'b0;
            end else if (ack_fall) begin
               if (sec_q == 4'(SECS - 1)) begin
                  if (state_q == WB) begin
                     dirty_d = 1'b0;
                     state_d = RD;
                     lba_d   = base(next_track_q);
                     sec_d   = 4'd0;
                     rd_d    = 1'b1;
                     wr_d    = 1'b0;
                  end else begin
                     loaded_d = 1'b1;
                     dirty_d  = 1'b0;
                     state_d  = IDLE;
                     wait_d   = 1'b0;
                     rd_d     = 1'b0;
                     wr_d     = 1'b0;
                  end
               end else begin
                  sec_d = sec_q + 4'd1;
                  lba_d = lba_q + 32'd1;
                  rd_d  = (state_q == RD);
                  wr_d  = (state_q == WB);
               end
            end
         end

         default: begin
            state_d = IDLE;
            rd_d    = 1'b0;
            wr_d    = 1'b0;
            wait_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         cur_track_q  <= '0;
         next_track_q <= '0;
         mount_pend_q <= 1'b0;
         dirty_q      <= 1'b0;
         loaded_q     <= 1'b0;
         lba_q        <= 32'd0;
         rd_q         <= 1'b0;
         wr_q         <= 1'b0;
         sec_q        <= 4'd0;
         wait_q       <= 1'b0;
         ack_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         cur_track_q  <= cur_track_d;
         next_track_q <= next_track_d;
         mount_pend_q <= mount_pend_d;
         dirty_q      <= dirty_d;
         loaded_q     <= loaded_d;
         lba_q        <= lba_d;
         rd_q         <= rd_d;
         wr_q         <= wr_d;
         sec_q        <= sec_d;
         wait_q       <= wait_d;
         ack_q        <= ack_d;
      end
   end

   assign sd_lba    = lba_q;
   assign sd_rd     = rd_q;
   assign sd_wr     = wr_q;
   assign track_sec = sec_q;
   assign cpu_wait  = wait_q;
   assign loaded    = loaded_q;
   assign dirty     = dirty_q;

endmodule

// File: tb/tb_fdd_track_sched.sv
// Scoreboard bench for fdd_track_sched: stimulus queues expected sector requests,
// a monitor pops and compares each new sd_rd/sd_wr request.
`timescale 1ns/1ps

module tb_fdd_track_sched;
   localparam int SECS  = 13;
   localparam int TRK_W = 6;

   logic             clk_sys = 1'b0;
   logic             reset_n = 1'b0;
   logic [TRK_W-1:0] track = '0;
   logic             dirty_set = 1'b0;
   logic             img_mounted = 1'b0;
   logic             img_present = 1'b1;
   logic             img_readonly = 1'b0;
   logic             sd_ack = 1'b0;
   logic [31:0]      sd_lba;
   logic             sd_rd;
   logic             sd_wr;
   logic [3:0]       track_sec;
   logic             cpu_wait;
   logic             loaded;
   logic             dirty;

   fdd_track_sched #(.SECS(SECS), .TRK_W(TRK_W)) dut (
      .clk_sys      (clk_sys),
      .reset_n      (reset_n),
      .track        (track),
      .dirty_set    (dirty_set),
      .img_mounted  (img_mounted),
      .img_present  (img_present),
      .img_readonly (img_readonly),
      .sd_ack       (sd_ack),
      .sd_lba       (sd_lba),
      .sd_rd        (sd_rd),
      .sd_wr        (sd_wr),
      .track_sec    (track_sec),
      .cpu_wait     (cpu_wait),
      .loaded       (loaded),
      .dirty        (dirty)
   );

   always #35 clk_sys = ~clk_sys;

   typedef struct packed {
      logic        wr;
      logic [31:0] lba;
      logic [3:0]  sec;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   checks   = 0;
   int   failures = 0;
   logic prv_rd   = 1'b0;
   logic prv_wr   = 1'b0;
   int   rsp_phase = 0;
   int   rsp_cnt   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   task automatic push_sec(input logic wr, input int trk, input int s);
      exp_t e;
      e.wr  = wr;
      e.lba = 32'(SECS * trk + s);
      e.sec = 4'(s);
      exp_q.push_back(e);
   endtask

   task automatic push_track(input logic wr, input int trk);
      for (int s = 0; s < SECS; s++) push_sec(wr, trk, s);
   endtask

   task automatic pulse_mount();
      @(posedge clk_sys); #1 img_mounted = 1'b1;
      @(posedge clk_sys); #1 img_mounted = 1'b0;
   endtask

   task automatic pulse_dirty();
      @(posedge clk_sys); #1 dirty_set = 1'b1;
      @(posedge clk_sys); #1 dirty_set = 1'b0;
      @(negedge clk_sys);
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      int stable = 0;
      while (n < 3000 && !(exp_q.size() == 0 && stable >= 4)) begin
         @(negedge clk_sys);
         n++;
         if (!cpu_wait && !sd_rd && !sd_wr) stable++;
         else stable = 0;
      end
      checks++;
      if (n >= 3000) begin
         failures++;
         $display("FAIL %s_timeout pending=%0d required=0", name, exp_q.size());
      end
   endtask

   // sd_ack responder: 2 cycles after a request, ack high for 3 cycles
   initial begin
      forever begin
         @(posedge clk_sys); #1;
         if (!reset_n) begin
            sd_ack    = 1'b0;
            rsp_phase = 0;
         end else begin
            case (rsp_phase)
               0: if (sd_rd || sd_wr) begin rsp_phase = 1; rsp_cnt = 2; end
               1: begin
                  rsp_cnt--;
                  if (rsp_cnt == 0) begin sd_ack = 1'b1; rsp_phase = 2; rsp_cnt = 3; end
               end
               default: begin
                  rsp_cnt--;
                  if (rsp_cnt == 0) begin sd_ack = 1'b0; rsp_phase = 0; end
               end
            endcase
         end
      end
   end

   // monitor
   initial begin
      forever begin
         @(negedge clk_sys);
         if (reset_n && ((sd_rd && !prv_rd) || (sd_wr && !prv_wr))) begin
            chk("rd_wr_exclusive", 32'(sd_rd & sd_wr), 32'd0);
            chk("cpu_wait_in_xfer", 32'(cpu_wait), 32'd1);
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_request wr=%0d lba=%0d required=none", sd_wr, sd_lba);
            end else begin
               mon_e = exp_q.pop_front();
               chk("req_is_write", 32'(sd_wr), 32'(mon_e.wr));
               chk("sd_lba", sd_lba, mon_e.lba);
               chk("track_sec", 32'(track_sec), 32'(mon_e.sec));
            end
         end
         prv_rd = sd_rd;
         prv_wr = sd_wr;
      end
   end

   initial begin
      int n;
      repeat (3) @(posedge clk_sys);
      @(negedge clk_sys);
      chk("rst_sd_lba", sd_lba, 32'd0);
      chk("rst_sd_rd", 32'(sd_rd), 32'd0);
      chk("rst_sd_wr", 32'(sd_wr), 32'd0);
      chk("rst_track_sec", 32'(track_sec), 32'd0);
      chk("rst_cpu_wait", 32'(cpu_wait), 32'd0);
      chk("rst_loaded", 32'(loaded), 32'd0);
      chk("rst_dirty", 32'(dirty), 32'd0);
      @(posedge clk_sys); #1 reset_n = 1'b1;

      // 1: initial mount, track 0
      push_track(1'b0, 0);
      pulse_mount();
      wait_done("t1");
      chk("t1_loaded", 32'(loaded), 32'd1);
      chk("t1_dirty", 32'(dirty), 32'd0);
      chk("t1_cpu_wait", 32'(cpu_wait), 32'd0);
      chk("t1_track_sec_hold", 32'(track_sec), 32'd12);

      // 2: clean move 0 -> 3
      push_track(1'b0, 3);
      track = 6'd3;
      wait_done("t2");
      chk("t2_loaded", 32'(loaded), 32'd1);
      chk("t2_dirty", 32'(dirty), 32'd0);

      // 3: dirty move 3 -> 4 writes back first
      pulse_dirty();
      chk("t3_dirty_set", 32'(dirty), 32'd1);
      push_track(1'b1, 3);
      push_track(1'b0, 4);
      track = 6'd4;
      wait_done("t3");
      chk("t3_dirty_end", 32'(dirty), 32'd0);
      chk("t3_loaded", 32'(loaded), 32'd1);

      // 4: read-only image ignores dirty_set
      img_readonly = 1'b1;
      pulse_dirty();
      chk("t4_dirty_ignored", 32'(dirty), 32'd0);
      push_track(1'b0, 3);
      track = 6'd3;
      wait_done("t4a");
      push_track(1'b0, 4);
      track = 6'd4;
      wait_done("t4b");
      chk("t4_dirty", 32'(dirty), 32'd0);
      img_readonly = 1'b0;

      // 5: mount during sector 5 of the track-4 read
      push_track(1'b0, 3);
      track = 6'd3;
      wait_done("t5a");
      pulse_dirty();
      chk("t5_dirty_set", 32'(dirty), 32'd1);
      push_track(1'b1, 3);
      push_track(1'b0, 4);
      push_track(1'b0, 4);
      track = 6'd4;
      n = 0;
      while (n < 2000 && !(sd_rd && sd_lba == 32'd57)) begin
         @(negedge clk_sys);
         n++;
      end
      chk("t5_reach_sector5", 32'(n < 2000), 32'd1);
      pulse_mount();
      wait_done("t5b");
      chk("t5_dirty", 32'(dirty), 32'd0);
      chk("t5_loaded", 32'(loaded), 32'd1);

      // 6: reset in the middle of a writeback
      pulse_dirty();
      chk("t6_dirty_set", 32'(dirty), 32'd1);
      push_sec(1'b1, 4, 0);
      push_sec(1'b1, 4, 1);
      push_sec(1'b1, 4, 2);
      track = 6'd5;
      n = 0;
      while (n < 2000 && !(sd_wr && track_sec == 4'd2)) begin
         @(negedge clk_sys);
         n++;
      end
      chk("t6_reach_wb", 32'(n < 2000), 32'd1);
      @(posedge clk_sys); #1 reset_n = 1'b0;
      @(negedge clk_sys);
      chk("t6_sd_wr", 32'(sd_wr), 32'd0);
      chk("t6_sd_rd", 32'(sd_rd), 32'd0);
      chk("t6_cpu_wait", 32'(cpu_wait), 32'd0);
      chk("t6_loaded", 32'(loaded), 32'd0);
      chk("t6_dirty", 32'(dirty), 32'd0);
      chk("t6_sd_lba", sd_lba, 32'd0);
      chk("t6_pending", 32'(exp_q.size()), 32'd0);
      track = 6'd0;
      @(posedge clk_sys);
      @(posedge clk_sys); #1 reset_n = 1'b1;
      push_track(1'b0, 0);
      pulse_mount();
      wait_done("t6_reload");
      chk("t6_reload_loaded", 32'(loaded), 32'd1);
      chk("t6_reload_dirty", 32'(dirty), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
